// File: rtl/exec_ctrl_pkg.sv
// Shared types and constants for the execution sequencer.
// State encoding, mode codes and default parameter values.
package exec_ctrl_pkg;

    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_RUN_DIV = 1_000_000;

    localparam logic [1:0] MODE_IDLE   = 2'd0;
    localparam logic [1:0] MODE_RUN    = 2'd1;
    localparam logic [1:0] MODE_HALTED = 2'd2;
    localparam logic [1:0] MODE_BUSY   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_FPGA_SETUP,
        S_FPGA_EXEC,
        S_RUN,
        S_HALTED
    } exec_state_t;

endpackage

// File: rtl/exec_controller_rate_divider.sv
// Modulo-DIV counter with enable, sync clear and terminal-count output.
// Reusable for any fixed-rate tick such as a display refresh.
module rate_divider
    import exec_ctrl_pkg::*;
#(
    parameter int DIV = DEF_RUN_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/exec_controller.sv
// Execution sequencer: turns button pulses into PC-enable strobes.
// Breakpoint stop in run mode is built with EXEC_CTRL_BREAKPOINT_EN.
module exec_controller
    import exec_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int RUN_DIV = DEF_RUN_DIV
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              step_pulse,
    input  logic              fpga_pulse,
    input  logic              run_toggle,
    input  logic              halt,
    input  logic [ADDR_W-1:0] curr_inst_addr,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_valid,
    output logic              pc_enable,
    output logic              inst_sel,
    output logic [1:0]        mode,
    output logic [CNT_W-1:0]  inst_count,
    output logic              bp_hit
);

    exec_state_t      state;
    logic             tick;
    logic             div_clear;
    logic             bp_stop;
    logic             bp_resume;
    logic [CNT_W-1:0] count_inc;

    // Divider only runs in RUN; every other state holds it at zero.
    assign div_clear = clear || (state != S_RUN);

    rate_divider #(
        .DIV(RUN_DIV)
    ) u_div (
        .clk(clk),
        .reset_n(reset_n),
        .clear(div_clear),
        .enable(state == S_RUN),
        .tick(tick)
    );

    assign count_inc = (inst_count == '1) ? inst_count
                                          : inst_count + CNT_W'(1);

`ifdef EXEC_CTRL_BREAKPOINT_EN
    // bp_resume lets the stopped-at instruction run once on resume.
    assign bp_stop = bp_valid && (curr_inst_addr == bp_addr) && !bp_resume;
`else
    assign bp_stop = 1'b0;
    wire unused_bp = ^{bp_addr, bp_valid, curr_inst_addr, bp_resume};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            pc_enable  <= 1'b0;
            inst_sel   <= 1'b0;
            mode       <= MODE_IDLE;
            inst_count <= '0;
            bp_hit     <= 1'b0;
            bp_resume  <= 1'b0;
        end else if (clear) begin
            state      <= S_IDLE;
            pc_enable  <= 1'b0;
            inst_sel   <= 1'b0;
            mode       <= MODE_IDLE;
            inst_count <= '0;
            bp_hit     <= 1'b0;
            bp_resume  <= 1'b0;
        end else begin
            pc_enable <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    inst_sel <= 1'b0;
                    if (run_toggle || step_pulse || fpga_pulse) begin
                        if (halt) begin
                            state <= S_HALTED;
                            mode  <= MODE_HALTED;
                        end else if (run_toggle) begin
                            state  <= S_RUN;
                            mode   <= MODE_RUN;
                            bp_hit <= 1'b0;
                        end else if (step_pulse) begin
                            state      <= S_STEP;
                            mode       <= MODE_BUSY;
                            pc_enable  <= 1'b1;
                            inst_count <= count_inc;
                            bp_hit     <= 1'b0;
                            bp_resume  <= 1'b0;
                        end else begin
                            state     <= S_FPGA_SETUP;
                            mode      <= MODE_BUSY;
                            inst_sel  <= 1'b1;
                            bp_hit    <= 1'b0;
                            bp_resume <= 1'b0;
                        end
                    end
                end
                S_STEP: begin
                    state <= S_IDLE;
                    mode  <= MODE_IDLE;
                end
                S_FPGA_SETUP: begin
                    state      <= S_FPGA_EXEC;
                    inst_sel   <= 1'b1;
                    pc_enable  <= 1'b1;
                    inst_count <= count_inc;
                end
                S_FPGA_EXEC: begin
                    state    <= S_IDLE;
                    mode     <= MODE_IDLE;
                    inst_sel <= 1'b0;
                end
                S_RUN: begin
                    if (halt) begin
                        state <= S_HALTED;
                        mode  <= MODE_HALTED;
                    end else if (run_toggle) begin
                        state <= S_IDLE;
                        mode  <= MODE_IDLE;
                    end else if (tick) begin
                        if (bp_stop) begin
                            state     <= S_IDLE;
                            mode      <= MODE_IDLE;
                            bp_hit    <= 1'b1;
                            bp_resume <= 1'b1;
                        end else begin
                            pc_enable  <= 1'b1;
                            inst_count <= count_inc;
                            bp_resume  <= 1'b0;
                        end
                    end
                end
                S_HALTED: begin
                    state <= S_HALTED;
                end
                default: begin
                    state <= S_IDLE;
                    mode  <= MODE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench for exec_controller with a strobe scoreboard.
module tb_exec_controller;

    localparam int AW  = 5;
    localparam int CW  = 16;
    localparam int DIV = 4;

    logic          clk;
    logic          reset_n;
    logic          clear;
    logic          step_pulse;
    logic          fpga_pulse;
    logic          run_toggle;
    logic          halt;
    logic [AW-1:0] pc;
    logic [AW-1:0] bp_addr;
    logic          bp_valid;

    logic          pc_enable;
    logic          inst_sel;
    logic [1:0]    mode;
    logic [CW-1:0] inst_count;
    logic          bp_hit;

    logic          s_pc_enable;
    logic          s_inst_sel;
    logic [1:0]    s_mode;
    logic [2:0]    s_count;
    logic          s_bp_hit;

    typedef struct packed {
        logic          sel;
        logic [CW-1:0] cnt;
        logic [AW-1:0] pc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    exec_controller #(.ADDR_W(AW), .CNT_W(CW), .RUN_DIV(DIV)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .step_pulse(step_pulse), .fpga_pulse(fpga_pulse),
        .run_toggle(run_toggle), .halt(halt),
        .curr_inst_addr(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
        .pc_enable(pc_enable), .inst_sel(inst_sel), .mode(mode),
        .inst_count(inst_count), .bp_hit(bp_hit)
    );

    // Narrow-counter copy exercises saturation in a handful of steps.
    exec_controller #(.ADDR_W(AW), .CNT_W(3), .RUN_DIV(DIV)) dut_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .step_pulse(step_pulse), .fpga_pulse(fpga_pulse),
        .run_toggle(run_toggle), .halt(halt),
        .curr_inst_addr(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
        .pc_enable(s_pc_enable), .inst_sel(s_inst_sel), .mode(s_mode),
        .inst_count(s_count), .bp_hit(s_bp_hit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc <= '0;
        else if (clear) pc <= '0;
        else if (pc_enable) pc <= pc + AW'(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && pc_enable === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_strobe: observed strobe at pc %0d expected none", pc);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("strobe_sel", 32'(inst_sel), 32'(e.sel));
                chk("strobe_cnt", 32'(inst_count), 32'(e.cnt));
                chk("strobe_pc", 32'(pc), 32'(e.pc));
            end
        end
    end

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sel, input int cnt, input int p);
        exp_t e;
        e.sel = sel;
        e.cnt = CW'(cnt);
        e.pc  = AW'(p);
        sb.push_back(e);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1; clear = 1'b0; step_pulse = 1'b0;
        fpga_pulse = 1'b0; run_toggle = 1'b0; halt = 1'b0;
        bp_addr = '0; bp_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_pc_enable", 32'(pc_enable), 0);
        chk("rst_inst_sel", 32'(inst_sel), 0);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_count", 32'(inst_count), 0);
        chk("rst_bp_hit", 32'(bp_hit), 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        push(1'b0, 1, 0);
        step_pulse = 1'b1; tick(); step_pulse = 1'b0;
        chk("step_en_k1", 32'(pc_enable), 1);
        chk("step_mode_busy", 32'(mode), 3);
        tick();
        chk("step_en_k2", 32'(pc_enable), 0);
        chk("step_mode_idle", 32'(mode), 0);
        chk("step_count", 32'(inst_count), 1);

        push(1'b1, 2, 1);
        fpga_pulse = 1'b1; tick(); fpga_pulse = 1'b0;
        chk("fpga_sel_k1", 32'(inst_sel), 1);
        chk("fpga_en_k1", 32'(pc_enable), 0);
        chk("fpga_mode_k1", 32'(mode), 3);
        tick();
        chk("fpga_sel_k2", 32'(inst_sel), 1);
        chk("fpga_en_k2", 32'(pc_enable), 1);
        tick();
        chk("fpga_sel_k3", 32'(inst_sel), 0);
        chk("fpga_en_k3", 32'(pc_enable), 0);
        chk("fpga_mode_k3", 32'(mode), 0);
        chk("fpga_count", 32'(inst_count), 2);

        push(1'b0, 3, 2); push(1'b0, 4, 3); push(1'b0, 5, 4);
        run_toggle = 1'b1; tick(); run_toggle = 1'b0;
        chk("run_mode", 32'(mode), 1);
        chk("run_entry_en", 32'(pc_enable), 0);
        for (int i = 1; i <= 13; i++) begin
            tick();
            chk("run_strobe", 32'(pc_enable), 32'(i % 4 == 0));
        end
        halt = 1'b1; tick();
        chk("halt_mode", 32'(mode), 2);
        step_pulse = 1'b1; tick(); step_pulse = 1'b0;
        repeat (5) tick();
        chk("halted_mode", 32'(mode), 2);
        chk("halted_count", 32'(inst_count), 5);
        halt = 1'b0;
        do_clear();
        chk("clear_mode", 32'(mode), 0);
        chk("clear_count", 32'(inst_count), 0);

        run_toggle = 1'b1; tick(); run_toggle = 1'b0;
        repeat (3) tick();
        halt = 1'b1; tick();
        chk("halt_tc_mode", 32'(mode), 2);
        chk("halt_tc_en", 32'(pc_enable), 0);
        halt = 1'b0;
        do_clear();

        halt = 1'b1; step_pulse = 1'b1; tick();
        halt = 1'b0; step_pulse = 1'b0;
        chk("idle_halt_mode", 32'(mode), 2);
        chk("idle_halt_en", 32'(pc_enable), 0);
        do_clear();

        run_toggle = 1'b1; tick(); run_toggle = 1'b0;
        repeat (3) tick();
        run_toggle = 1'b1; tick(); run_toggle = 1'b0;
        chk("toggle_tc_mode", 32'(mode), 0);
        chk("toggle_tc_en", 32'(pc_enable), 0);
        repeat (4) tick();
        chk("toggle_stay_idle", 32'(mode), 0);

        run_toggle = 1'b1; step_pulse = 1'b1; fpga_pulse = 1'b1; tick();
        run_toggle = 1'b0; step_pulse = 1'b0; fpga_pulse = 1'b0;
        chk("simul_mode", 32'(mode), 1);
        chk("simul_en", 32'(pc_enable), 0);
        chk("simul_sel", 32'(inst_sel), 0);
        tick(); tick();
        run_toggle = 1'b1; tick(); run_toggle = 1'b0;
        chk("simul_exit", 32'(mode), 0);
        chk("simul_count", 32'(inst_count), 0);

        do_clear();
        for (int n = 1; n <= 9; n++) begin
            push(1'b0, n, n - 1);
            step_pulse = 1'b1; tick(); step_pulse = 1'b0;
            tick();
            chk("sat_count", 32'(s_count), (n > 7) ? 7 : n);
        end
        chk("wide_count", 32'(inst_count), 9);

        run_toggle = 1'b1; tick(); run_toggle = 1'b0;
        tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        chk("midrun_rst_mode", 32'(mode), 0);
        chk("midrun_rst_count", 32'(inst_count), 0);
        chk("midrun_rst_en", 32'(pc_enable), 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_mode", 32'(mode), 0);
        chk("post_rst_count", 32'(inst_count), 0);

        bp_addr = 5'd3; bp_valid = 1'b1;
`ifdef EXEC_CTRL_BREAKPOINT_EN
        push(1'b0, 1, 0); push(1'b0, 2, 1); push(1'b0, 3, 2);
        run_toggle = 1'b1; tick(); run_toggle = 1'b0;
        repeat (16) tick();
        chk("bp_stop_mode", 32'(mode), 0);
        chk("bp_stop_hit", 32'(bp_hit), 1);
        chk("bp_stop_count", 32'(inst_count), 3);
        push(1'b0, 4, 3);
        run_toggle = 1'b1; tick(); run_toggle = 1'b0;
        chk("bp_resume_hit", 32'(bp_hit), 0);
        chk("bp_resume_mode", 32'(mode), 1);
        repeat (4) tick();
        run_toggle = 1'b1; tick(); run_toggle = 1'b0;
        chk("bp_resume_count", 32'(inst_count), 4);
        chk("bp_resume_exit", 32'(mode), 0);
`else
        push(1'b0, 1, 0); push(1'b0, 2, 1); push(1'b0, 3, 2);
        push(1'b0, 4, 3); push(1'b0, 5, 4);
        run_toggle = 1'b1; tick(); run_toggle = 1'b0;
        repeat (16) tick();
        chk("nobp_mode", 32'(mode), 1);
        chk("nobp_hit", 32'(bp_hit), 0);
        repeat (4) tick();
        run_toggle = 1'b1; tick(); run_toggle = 1'b0;
        chk("nobp_count", 32'(inst_count), 5);
        chk("nobp_exit", 32'(mode), 0);
`endif
        bp_valid = 1'b0;
        tick();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_controller.md
Name: exec_controller

Overview:
Execution sequencer for the single-cycle MIPS FPGA top.
- Turns debounced button pulses into properly timed PC-enable strobes.
- Drives the instruction-source select: imem or FPGA switches.
- Provides a free-running "run" mode at a programmable rate and stops on processor halt.
- Sits between the debounce instances and the PC / selector / mips instances; replaces the direct pulse-to-enable wiring.

Parameters:
ADDR_W, 5, instruction address width (matches PC / imem)
CNT_W, 16, retired-instruction counter width
RUN_DIV, 1_000_000, clock cycles per instruction in run mode (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous soft clear (same pulse that resets processor/dmem)
step_pulse  in  1  one-cycle request: execute next imem instruction
fpga_pulse  in  1  one-cycle request: execute instruction from FPGA switches
run_toggle  in  1  one-cycle request: enter/leave run mode
halt  in  1  processor halt flag (level)
curr_inst_addr  in  ADDR_W  current PC value
bp_addr  in  ADDR_W  breakpoint address
bp_valid  in  1  breakpoint armed
pc_enable  out  1  one-cycle PC advance strobe
inst_sel  out  1  0 = imem, 1 = FPGA switches
mode  out  2  0 IDLE, 1 RUN, 2 HALTED, 3 BUSY
inst_count  out  CNT_W  instructions retired since clear
bp_hit  out  1  sticky breakpoint-stop flag

Behaviour:
- Reset (reset_n low, async): state IDLE; pc_enable=0, inst_sel=0, mode=0, inst_count=0, bp_hit=0, divider=0. All outputs are registered.
- clear (sync): highest priority in every state; same effect as reset. Any pending strobe is dropped.
- States: IDLE, STEP, FPGA_SETUP, FPGA_EXEC, RUN, HALTED.
- IDLE transitions:
  - Request priority when several arrive in the same cycle: run_toggle > step_pulse > fpga_pulse.
  - If halt=1 at the sampling edge, any request goes to HALTED with no strobe.
- STEP (1 cycle):
  - Request sampled at edge k; pc_enable=1 only in cycle k+1.
  - inst_count increments; state returns to IDLE.
- FPGA_SETUP then FPGA_EXEC:
  - inst_sel=1 in cycles k+1 and k+2; pc_enable=1 only in k+2, so the switch instruction settles for a full cycle first.
  - inst_count increments; inst_sel=0 again from k+3; state returns to IDLE.
- RUN:
  - Entering clears the divider and bp_hit. The divider counts 0..RUN_DIV-1.
  - At terminal count: pc_enable=1 for one cycle, inst_count increments, divider wraps to 0.
  - First strobe occurs RUN_DIV cycles after entry.
  - step_pulse and fpga_pulse are ignored.
  - run_toggle returns to IDLE; an in-progress tick is discarded.
  - halt=1 returns to HALTED with no strobe, including at terminal count.
- HALTED: no strobes, all requests ignored. Only clear or reset exits.
- mode: 0 IDLE; 1 RUN; 2 HALTED; 3 STEP, FPGA_SETUP or FPGA_EXEC.
- inst_count saturates at all-ones and never wraps.
- bp_hit clears on clear, on entry to RUN, or on accepted step_pulse/fpga_pulse.

Optional Feature:
EXEC_CTRL_BREAKPOINT_EN
- Defined:
  - In RUN at terminal count, if bp_valid && curr_inst_addr==bp_addr: no strobe, state goes to IDLE, bp_hit=1.
  - Resuming RUN from that address executes it normally.
  - The check applies at terminal counts only, never on the entry edge.
- Undefined: bp_addr and bp_valid are ignored; bp_hit is tied 0.

Decomposition:
- Package exec_ctrl_pkg holds:
  - state enum exec_state_t;
  - mode encoding constants MODE_IDLE, MODE_RUN, MODE_HALTED, MODE_BUSY;
  - default parameter constants.
- One sub-module, rate_divider: enable/clear-able modulo-RUN_DIV counter with a terminal-count output. It is reusable for the seven-segment refresh.

Test Plan (RUN_DIV=4 in simulation):
- Reset: reset_n low mid-RUN -> all outputs 0 immediately; after release, mode=0 and inst_count=0.
- Step: step_pulse at edge k, halt=0 -> pc_enable high only in cycle k+1; inst_count=1; mode 3 then 0.
- FPGA: fpga_pulse at edge k -> inst_sel=1 in k+1 and k+2, pc_enable only in k+2; inst_count increments; inst_sel=0 at k+3.
- Run/halt: run_toggle, then 12 cycles -> strobes at cycles 4, 8, 12 after entry; halt raised at cycle 14 -> mode=2, no further strobes; step_pulse ignored; clear -> mode=0, inst_count=0.
- Simultaneous: run_toggle+step_pulse+fpga_pulse in the same cycle from IDLE -> RUN, no immediate strobe. Saturation: force inst_count=16'hFFFE, two steps -> 16'hFFFF held.
- Breakpoint (macro defined): bp_addr=5'd3, bp_valid=1, RUN from PC 0 -> strobes at PC 0, 1, 2; at PC 3 state goes IDLE, bp_hit=1, no strobe. run_toggle -> bp_hit=0 and PC 3 executes. With macro undefined -> run continues past PC 3 and bp_hit stays 0.
